// File: rtl/soc_pkg.sv
// Shared definitions for the boot loader and its byte packer.
package soc_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [3:0]  WMASK_FULL = 4'b1111;
   localparam logic [3:0]  WMASK_NONE = 4'b0000;

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Gathers accepted stream bytes into a little-endian word; the word and its
// valid are combinational in the cycle the last byte is accepted.
module byte_packer
   import soc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic [7:0]  i_data,
   input  logic        i_valid,
   input  logic        i_ready,
   output logic [31:0] o_word_c,
   output logic        o_word_valid_c
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [1:0]  r_idx;
   logic [31:0] r_shift;
   logic        w_accept;

   assign w_accept       = i_valid & i_ready;
   // New byte enters at the top so byte 0 ends up in bits [7:0] after four shifts.
   assign o_word_c       = {i_data, r_shift[31:8]};
   assign o_word_valid_c = w_accept && (r_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_idx   <= 2'd0;
         r_shift <= 32'd0;
      end else if (w_accept) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= o_word_c;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a length-prefixed image into memory over the shared bus,
// optionally reads each word back, then releases the core from reset.
module boot_loader
   import soc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned SIZE_WORDS = 2048,
   parameter logic        VERIFY     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   output logic        bus_wen,
   output logic        bus_ren,
   input  logic [31:0] bus_rdata,
   input  logic        bus_done,
   output logic        cpu_rst,
   output logic        load_done,
   output logic        load_error
);

   localparam logic [31:0] SIZE_LIMIT = 32'(SIZE_WORDS);
   localparam logic [31:0] ADDR_STEP  = 32'(WORD_BYTES);

   loader_state_e r_state, w_state_nxt;
   logic [31:0]   r_count, w_count_nxt;
   logic [31:0]   r_written, w_written_nxt;
   logic [31:0]   r_bus_addr, w_addr_nxt;
   logic [31:0]   r_bus_wdata, w_wdata_nxt;
   logic          r_bus_wen, w_wen_nxt;
   logic          r_bus_ren, w_ren_nxt;
   logic [3:0]    r_bus_wmask;
   logic          r_in_ready, r_cpu_rst, r_load_done, r_load_error;
   logic          w_advance, w_pack_clear;
   logic [31:0]   w_word_c;
   logic          w_word_valid_c;

   assign w_pack_clear = (r_state == ST_DONE) || (r_state == ST_ERROR);

   byte_packer u_packer (
      .clk            (clk),
      .rst            (rst),
      .i_clear        (w_pack_clear),
      .i_data         (in_data),
      .i_valid        (in_valid),
      .i_ready        (r_in_ready),
      .o_word_c       (w_word_c),
      .o_word_valid_c (w_word_valid_c)
   );

   // Next-state and next-value logic for the loader.
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_written_nxt = r_written;
      w_addr_nxt    = r_bus_addr;
      w_wdata_nxt   = r_bus_wdata;
      w_wen_nxt     = r_bus_wen;
      w_ren_nxt     = r_bus_ren;
      w_advance     = 1'b0;
      unique case (r_state)
         ST_LEN: begin
            if (w_word_valid_c) begin
               w_count_nxt = w_word_c;
               if (w_word_c == 32'd0)           w_state_nxt = ST_DONE;
               else if (w_word_c > SIZE_LIMIT)  w_state_nxt = ST_ERROR;
               else                             w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_valid_c) begin
               w_wdata_nxt = w_word_c;
               w_wen_nxt   = 1'b1;
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (bus_done && r_bus_wen) begin
               w_wen_nxt = 1'b0;
               if (VERIFY) begin
                  w_ren_nxt   = 1'b1;
                  w_state_nxt = ST_READ;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (bus_done && r_bus_ren) begin
               w_ren_nxt = 1'b0;
               // On mismatch the address is left pointing at the failing word.
               if (bus_rdata != r_bus_wdata) w_state_nxt = ST_ERROR;
               else                          w_advance   = 1'b1;
            end
         end
         default: ;
      endcase
      if (w_advance) begin
         w_written_nxt = r_written + 32'd1;
         w_addr_nxt    = r_bus_addr + ADDR_STEP;
         if (w_written_nxt == r_count) w_state_nxt = ST_DONE;
         else                          w_state_nxt = ST_DATA;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_LEN;
         r_count      <= 32'd0;
         r_written    <= 32'd0;
         r_bus_addr   <= BASE_ADDR;
         r_bus_wdata  <= 32'd0;
         r_bus_wen    <= 1'b0;
         r_bus_ren    <= 1'b0;
         r_bus_wmask  <= WMASK_NONE;
         r_in_ready   <= 1'b0;
         r_cpu_rst    <= 1'b1;
         r_load_done  <= 1'b0;
         r_load_error <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_written    <= w_written_nxt;
         r_bus_addr   <= w_addr_nxt;
         r_bus_wdata  <= w_wdata_nxt;
         r_bus_wen    <= w_wen_nxt;
         r_bus_ren    <= w_ren_nxt;
         r_bus_wmask  <= w_wen_nxt ? WMASK_FULL : WMASK_NONE;
         r_in_ready   <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA);
         r_cpu_rst    <= (w_state_nxt != ST_DONE);
         r_load_done  <= (w_state_nxt == ST_DONE);
         r_load_error <= (w_state_nxt == ST_ERROR);
      end
   end

   assign in_ready   = r_in_ready;
   assign bus_addr   = r_bus_addr;
   assign bus_wdata  = r_bus_wdata;
   assign bus_wmask  = r_bus_wmask;
   assign bus_wen    = r_bus_wen;
   assign bus_ren    = r_bus_ren;
   assign cpu_rst    = r_cpu_rst;
   assign load_done  = r_load_done;
   assign load_error = r_load_error;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of image loads against a latency-randomised
// memory model with a transaction scoreboard, plus a mid-write reset sequence.
`timescale 1ns/1ps
module tb_boot_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int unsigned SIZE = 2048;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_wen, bus_ren;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_done = 1'b0;
   logic        cpu_rst, load_done, load_error;

   boot_loader #(.BASE_ADDR(BASE), .SIZE_WORDS(SIZE), .VERIFY(1'b1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
      .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_done(bus_done),
      .cpu_rst(cpu_rst), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      string       name;
      logic [31:0] count;
      int          nsend;
      logic [31:0] data0;
      int          gap_pct;
      int          lat_max;
      bit          corrupt;
      int          exp_txn;
      logic        exp_done;
      logic        exp_error;
      logic [31:0] exp_addr;
   } vec_t;

   int          n_checks = 0, n_errors = 0;
   txn_t        sb_q[$];
   txn_t        m_exp;
   logic [31:0] mem [0:SIZE-1];
   logic [10:0] m_idx;
   int          mem_lat_max = 0, cur_lat = 0, mem_cnt = 0;
   bit          mem_hold = 1'b0, corrupt = 1'b0;
   int          n_txn = 0, n_unexp = 0, n_viol = 0, n_timeouts = 0;
   bit          done_q = 1'b0, p_wen = 1'b0, p_ren = 1'b0;
   logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
   vec_t        vecs [6];
   vec_t        reload;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wdat(input vec_t v, input int i);
      return v.data0 + 32'(i) * 32'h0101_0101;
   endfunction

   // Memory model and bus protocol monitor, evaluated away from the active edge.
   always @(negedge clk) begin
      if (bus_wen && bus_ren) n_viol++;
      if (bus_wmask != (bus_wen ? 4'b1111 : 4'b0000)) n_viol++;
      if (done_q) begin
         if ((p_wen && bus_wen) || (p_ren && bus_ren)) n_viol++;
      end else if ((p_wen && bus_wen) || (p_ren && bus_ren)) begin
         if (bus_addr != p_addr || bus_wdata != p_wdata) n_viol++;
      end
      if (bus_done) begin
         bus_done = 1'b0;
         mem_cnt  = 0;
      end else if ((bus_wen || bus_ren) && !mem_hold) begin
         if (mem_cnt >= cur_lat) begin
            m_idx = bus_addr[12:2];
            n_txn++;
            if (sb_q.size() == 0) begin
               n_unexp++;
            end else begin
               m_exp = sb_q.pop_front();
               check("txn_kind", {31'b0, bus_wen}, {31'b0, m_exp.wr});
               check("txn_addr", bus_addr, m_exp.addr);
               if (m_exp.wr) check("txn_wdata", bus_wdata, m_exp.data);
            end
            if (bus_wen) mem[m_idx] = bus_wdata;
            else bus_rdata = mem[m_idx] ^ ((corrupt && m_idx == 11'd1) ? 32'h0000_0100 : 32'h0);
            bus_done = 1'b1;
            mem_cnt  = 0;
            cur_lat  = (mem_lat_max == 0) ? 0 : int'($urandom_range(mem_lat_max, 0));
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
      done_q  = bus_done;
      p_wen   = bus_wen;
      p_ren   = bus_ren;
      p_addr  = bus_addr;
      p_wdata = bus_wdata;
   end

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int  guard = 0;
      bit  rdy = 1'b0;
      while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      do begin
         rdy = in_ready;
         @(posedge clk); #1;
         guard++;
      end while (!rdy && guard < 200);
      if (!rdy) n_timeouts++;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_pct);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; mem_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst/in_ready", {31'b0, in_ready}, 32'd0);
      check("rst/strobes", {30'b0, bus_wen, bus_ren}, 32'd0);
      check("rst/addr", bus_addr, BASE);
      check("rst/wdata", bus_wdata, 32'd0);
      check("rst/wmask", {28'b0, bus_wmask}, 32'd0);
      check("rst/flags", {29'b0, cpu_rst, load_done, load_error}, 32'b100);
      sb_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst/in_ready_after", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run_vector(input vec_t v, input bit do_rst);
      int guard = 0;
      int bad = 0;
      if (do_rst) do_reset();
      mem_lat_max = v.lat_max; corrupt = v.corrupt;
      n_txn = 0; n_unexp = 0; n_viol = 0; n_timeouts = 0;
      for (int i = 0; i < v.nsend; i++) begin
         sb_q.push_back('{wr: 1'b1, addr: BASE + 32'(4 * i), data: wdat(v, i)});
         sb_q.push_back('{wr: 1'b0, addr: BASE + 32'(4 * i), data: wdat(v, i)});
      end
      send_word(v.count, v.gap_pct);
      if (v.nsend == 0)
         check({v.name, "/flags_next_cycle"}, {30'b0, load_error, load_done},
               {30'b0, v.exp_error, v.exp_done});
      for (int i = 0; i < v.nsend; i++) send_word(wdat(v, i), v.gap_pct);
      while (!(load_done || load_error) && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 500) n_timeouts++;
      in_data = 8'hA5; in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check({v.name, "/in_ready_closed"}, {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      check({v.name, "/done"}, {31'b0, load_done}, {31'b0, v.exp_done});
      check({v.name, "/error"}, {31'b0, load_error}, {31'b0, v.exp_error});
      check({v.name, "/cpu_rst"}, {31'b0, cpu_rst}, {31'b0, ~v.exp_done});
      check({v.name, "/addr"}, bus_addr, v.exp_addr);
      check({v.name, "/strobes_idle"}, {30'b0, bus_wen, bus_ren}, 32'd0);
      check({v.name, "/txn_count"}, 32'(n_txn), 32'(v.exp_txn));
      check({v.name, "/sb_left"}, 32'(sb_q.size()), 32'd0);
      check({v.name, "/unexpected"}, 32'(n_unexp), 32'd0);
      check({v.name, "/protocol"}, 32'(n_viol), 32'd0);
      check({v.name, "/timeouts"}, 32'(n_timeouts), 32'd0);
      if (v.exp_done) begin
         for (int i = 0; i < v.nsend; i++) if (mem[i] !== wdat(v, i)) bad++;
         check({v.name, "/mem_image"}, 32'(bad), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{"one_word",   32'd1,    1,    32'hEFBE_ADDE, 0,  0, 1'b0, 2,    1'b1, 1'b0, 32'h4};
      vecs[1] = '{"zero_len",   32'd0,    0,    32'h0,         0,  0, 1'b0, 0,    1'b1, 1'b0, 32'h0};
      vecs[2] = '{"oversize",   32'd2049, 0,    32'h0,         0,  0, 1'b0, 0,    1'b0, 1'b1, 32'h0};
      vecs[3] = '{"three_gaps", 32'd3,    3,    32'h1234_5678, 40, 3, 1'b0, 6,    1'b1, 1'b0, 32'hC};
      vecs[4] = '{"corrupt_w1", 32'd3,    2,    32'hA5A5_0001, 0,  1, 1'b1, 4,    1'b0, 1'b1, 32'h4};
      vecs[5] = '{"full_size",  32'd2048, 2048, 32'h0F0F_0000, 0,  0, 1'b0, 4096, 1'b1, 1'b0, 32'h2000};
      reload  = '{"reload",     32'd3,    3,    32'h7788_9900, 10, 2, 1'b0, 6,    1'b1, 1'b0, 32'hC};

      for (int n = 0; n < 6; n++) run_vector(vecs[n], 1'b1);

      // Reset while the third word's write strobe is outstanding.
      do_reset();
      mem_lat_max = 0; corrupt = 1'b0; n_unexp = 0; n_timeouts = 0;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back('{wr: 1'b1, addr: BASE + 32'(4 * i), data: wdat(reload, i)});
         sb_q.push_back('{wr: 1'b0, addr: BASE + 32'(4 * i), data: wdat(reload, i)});
      end
      send_word(32'd3, 0);
      send_word(wdat(reload, 0), 0);
      send_word(wdat(reload, 1), 0);
      send_byte(wdat(reload, 2) >> 0, 0);
      mem_hold = 1'b1;
      for (int k = 1; k < 4; k++) send_byte(8'(wdat(reload, 2) >> (8 * k)), 0);
      check("rstmid/wen_before", {31'b0, bus_wen}, 32'd1);
      check("rstmid/addr_before", bus_addr, BASE + 32'h8);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid/strobes", {30'b0, bus_wen, bus_ren}, 32'd0);
      check("rstmid/in_ready", {31'b0, in_ready}, 32'd0);
      check("rstmid/addr", bus_addr, BASE);
      check("rstmid/wdata", bus_wdata, 32'd0);
      check("rstmid/wmask", {28'b0, bus_wmask}, 32'd0);
      check("rstmid/flags", {29'b0, cpu_rst, load_done, load_error}, 32'b100);
      check("rstmid/sb_left", 32'(sb_q.size()), 32'd0);
      check("rstmid/unexpected", 32'(n_unexp), 32'd0);
      check("rstmid/timeouts", 32'(n_timeouts), 32'd0);
      rst = 1'b0;
      mem_hold = 1'b0;
      run_vector(reload, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Bus initiator that fills the SoC memory from a byte stream before the core runs.
- Drives the same addr/wdata/wmask/wstrobe/rstrobe/rdata/done bus as the core. It sits in front of the memory through a 2:1 initiator mux, which lives outside this block.
- Holds the core in reset until the image is written and, optionally, read back and verified.
- Stream format: 4-byte little-endian word count, then payload words, each 4 bytes little-endian.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first payload word.
- SIZE_WORDS, 2048, memory capacity in 32-bit words; larger images are rejected.
- VERIFY, 1, when 1 each written word is read back and compared.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  byte accepted when in_valid && in_ready
- bus_addr  output  32  word-aligned byte address
- bus_wdata  output  32  write data
- bus_wmask  output  4  byte enables
- bus_wen  output  1  write strobe
- bus_ren  output  1  read strobe
- bus_rdata  input  32  read data, valid with bus_done
- bus_done  input  1  single-cycle completion pulse from memory
- cpu_rst  output  1  reset to core; high until load completes
- load_done  output  1  image loaded (sticky until rst)
- load_error  output  1  oversize image or verify mismatch (sticky until rst)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = LEN; in_ready = 0 during reset, 1 from the first cycle after rst deasserts.
  - bus_wen = bus_ren = 0; bus_addr = BASE_ADDR; bus_wdata = 0; bus_wmask = 0.
  - cpu_rst = 1; load_done = 0; load_error = 0.
  - Byte index = 0; word count = 0; words written = 0.
- Bus rules:
  - A strobe stays high with addr/wdata/wmask stable until bus_done is sampled high.
  - The strobe drops in the cycle after done.
  - Never wen and ren together.
  - bus_done while no strobe is active is ignored.
  - bus_wmask = 4'b1111 on writes, 4'b0000 otherwise.
- States:
  - LEN:
    - in_ready = 1; accepts 4 bytes; byte k fills bits [8k+7:8k].
    - On the 4th byte, if count == 0: go to DONE.
    - If count > SIZE_WORDS: go to ERROR; no bus traffic at any point.
    - Otherwise go to DATA.
  - DATA:
    - in_ready = 1; assembles 4 bytes into bus_wdata.
    - The 4th accepted byte moves to WRITE next cycle with bus_wen = 1.
  - WRITE:
    - in_ready = 0; wait for bus_done.
    - If VERIFY: go to READ with bus_ren = 1, same address.
    - Else: increment words written; bus_addr += 4.
    - Then go to DONE if words written == count, else DATA.
  - READ:
    - On bus_done, compare bus_rdata to bus_wdata.
    - Mismatch: go to ERROR; bus_addr holds the failing address.
    - Match: advance as in WRITE.
  - DONE:
    - in_ready = 0; load_done = 1; cpu_rst = 0.
    - Further stream bytes are never accepted.
  - ERROR:
    - in_ready = 0; load_error = 1; cpu_rst stays 1.
- Stream gaps: in_valid low mid-word stalls assembly and preserves the partial byte index.
- Address rule: bus_addr = BASE_ADDR + 4*words_written, 32-bit wrap.
- Last word: the last word at index SIZE_WORDS-1 is legal; count == SIZE_WORDS is accepted.
- Reset mid-operation: any active strobe drops in the cycle rst is sampled. All state returns to reset values and the loader restarts at LEN. A half-written bus transaction is abandoned, because memory writes are idempotent per word.
- Throughput: minimum 4 stream cycles + 1 bus write + (VERIFY) 1 bus read per word, plus memory latency.

Decomposition:
- Shared package soc_pkg:
  - loader state enum (LEN, DATA, WRITE, READ, DONE, ERROR).
  - WMASK_FULL = 4'b1111, WMASK_NONE = 4'b0000.
  - WORD_BYTES = 4.
- One sub-module, byte_packer:
  - Accepts bytes with valid/ready, emits a 32-bit little-endian word plus a one-cycle word_valid.
  - Has a clear input; a 2-bit index and a 32-bit shift register.
  - The FSM, address and count logic stay in boot_loader.

Test Plan:
- Stream 01 00 00 00, then DE AD BE EF, against the memory model with VERIFY=1.
  - One write: addr 0x0, wdata 0xEFBEADDE, wmask 1111.
  - Then one read at 0x0.
  - load_done = 1, cpu_rst = 0.
- Stream count 0 (00 00 00 00):
  - No bus strobes ever.
  - load_done = 1 the cycle after the 4th byte.
- Count 2049 with SIZE_WORDS = 2048:
  - load_error = 1, no strobes, cpu_rst = 1.
  - in_ready = 0 afterwards.
- Three-word image with random in_valid gaps and memory done latency of 0–3 cycles:
  - Addresses 0x0, 0x4, 0x8 in order.
  - Strobes held until done; never wen and ren together.
- Memory model corrupting the readback of word 1 (VERIFY=1):
  - load_error = 1 with bus_addr = 0x4.
  - No write to 0x8; cpu_rst stays 1.
- Assert rst while bus_wen is high on word 2:
  - Strobes low next cycle; outputs at reset values.
  - A re-sent full image then loads cleanly to load_done.
